// File: rtl/keypad_bcd_encoder_seq.sv
// keypad_bcd_encoder_seq
// Debounced keypad encoder. The N_KEYS raw key lines pass through a
// two-flop synchronizer. The synchronized pattern must then stay stable
// for DEBOUNCE_CYCLES samples before it is accepted. An accepted one-hot
// pattern is reported as its index through a valid/ready handshake. The
// encoder stays disarmed until a debounced full release has been seen.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   d          raw key lines (asynchronous, active-high), line i encodes to i
//   key_ready  consumer accepts key_code while key_valid is high
//   key_code   index of the accepted key, zero-extended to CODE_W
//   key_valid  key_code valid, held until accepted
//   key_err    one-cycle pulse: the debounced pattern was multi-hot
//
// Optional build macro: KEY_PRIORITY_ENCODE_EN
//   Defined   - a multi-hot pattern emits its lowest set index and pulses
//               key_err on the same edge.
//   Undefined - a multi-hot pattern is dropped and only key_err pulses.
module keypad_bcd_encoder_seq #(
  parameter int N_KEYS          = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] d,
  input  logic              key_ready,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  output logic              key_err
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_EMIT     = 2'd2;
  localparam logic [1:0] ST_HOLD     = 2'd3;

  if (N_KEYS < 2 || N_KEYS > 16) begin : g_bad_n_keys
    $error("keypad_bcd_encoder_seq: N_KEYS must be in 2..16");
  end
  if (CODE_W < $clog2(N_KEYS)) begin : g_bad_code_w
    $error("keypad_bcd_encoder_seq: CODE_W too narrow for N_KEYS");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("keypad_bcd_encoder_seq: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [N_KEYS-1:0] sync_p0;
  logic [N_KEYS-1:0] sync_p1;
  logic [N_KEYS-1:0] s;
  logic [N_KEYS-1:0] cand;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        state;

  function automatic logic [CODE_W-1:0] lowest_index(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic is_one_hot(input logic [N_KEYS-1:0] v);
    return (v != '0) && ((v & (v - N_KEYS'(1))) == '0);
  endfunction

  // Synchronizer stage: d is asynchronous, only s is used downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign s = sync_p1;

  // Control stage: debounce, emit, wait for release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cand      <= '0;
      cnt       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_err   <= 1'b0;
    end else begin
      key_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (s != '0) begin
            state <= ST_DEBOUNCE;
            cand  <= s;
            cnt   <= '0;
          end
        end
        ST_DEBOUNCE: begin
          if (s == '0) begin
            state <= ST_IDLE;
          end else if (s != cand) begin
            cand <= s;
            cnt  <= '0;
          end else if (cnt == CNT_LAST) begin
            // The release count in HOLD starts from zero after acceptance.
            cnt <= '0;
            if (is_one_hot(cand)) begin
              key_code  <= lowest_index(cand);
              key_valid <= 1'b1;
              state     <= ST_EMIT;
            end else begin
`ifdef KEY_PRIORITY_ENCODE_EN
              key_code  <= lowest_index(cand);
              key_valid <= 1'b1;
              key_err   <= 1'b1;
              state     <= ST_EMIT;
`else
              key_err   <= 1'b1;
              state     <= ST_HOLD;
`endif
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_EMIT: begin
          // A release here does not cancel the code; only acceptance does.
          if (key_ready) begin
            key_valid <= 1'b0;
            state     <= ST_HOLD;
            cnt       <= '0;
          end
        end
        ST_HOLD: begin
          if (s != '0) begin
            cnt <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_bcd_encoder_seq.sv
// Testbench for keypad_bcd_encoder_seq (default parameters).
// Holds a behavioural model that states the rules in terms of sample run
// lengths. A pattern is accepted once the same nonzero synchronized value
// has been seen DB+1 times in a row while armed. Re-arming requires DB
// consecutive zero samples after the code was taken.
module tb_keypad_bcd_encoder_seq;

  localparam int N_KEYS = 10;
  localparam int CODE_W = 4;
  localparam int DB     = 4;

  localparam int ARMED = 0;
  localparam int PEND  = 1;
  localparam int REL   = 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic [N_KEYS-1:0] d = '0;
  logic              key_ready = 1'b0;
  logic [CODE_W-1:0] key_code;
  logic              key_valid;
  logic              key_err;

  int n_tests = 0;
  int n_fail  = 0;

  keypad_bcd_encoder_seq #(
    .N_KEYS(N_KEYS),
    .CODE_W(CODE_W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .d(d),
    .key_ready(key_ready),
    .key_code(key_code),
    .key_valid(key_valid),
    .key_err(key_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N_KEYS-1:0] key(input int k);
    logic [N_KEYS-1:0] v;
    v = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  function automatic int lowest(input logic [N_KEYS-1:0] v);
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) return i;
    end
    return 0;
  endfunction

  // ---------------- behavioural model ----------------
  logic [N_KEYS-1:0] m_dly0, m_dly1, m_last;
  int                m_phase, m_run, m_zeros;
  logic [CODE_W-1:0] exp_code;
  logic              exp_valid, exp_err;

  task automatic model_reset();
    m_dly0 = '0; m_dly1 = '0; m_last = '0;
    m_phase = ARMED; m_run = 0; m_zeros = 0;
    exp_code = '0; exp_valid = 1'b0; exp_err = 1'b0;
  endtask

  initial begin : model
    logic [N_KEYS-1:0] smp;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        model_reset();
      end else begin
        smp = m_dly1;
        m_dly1 = m_dly0;
        m_dly0 = d;
        exp_err = 1'b0;
        case (m_phase)
          ARMED: begin
            if (smp == '0) begin
              m_run = 0; m_last = '0;
            end else if (smp == m_last) begin
              m_run++;
            end else begin
              m_last = smp; m_run = 1;
            end
            if (m_run == DB + 1) begin
              if ($countones(smp) == 1) begin
                exp_valid = 1'b1; exp_code = CODE_W'(lowest(smp)); m_phase = PEND;
              end else begin
`ifdef KEY_PRIORITY_ENCODE_EN
                exp_valid = 1'b1; exp_code = CODE_W'(lowest(smp));
                exp_err = 1'b1; m_phase = PEND;
`else
                exp_err = 1'b1; m_phase = REL; m_zeros = 0;
`endif
              end
            end
          end
          PEND: begin
            if (key_ready) begin
              exp_valid = 1'b0; m_phase = REL; m_zeros = 0;
            end
          end
          default: begin
            if (smp != '0) m_zeros = 0;
            else begin
              m_zeros++;
              if (m_zeros == DB) begin
                m_phase = ARMED; m_run = 0; m_last = '0;
              end
            end
          end
        endcase
      end
    end
  end

  initial begin : compare
    forever begin
      @(posedge clk);
      #1;
      if (rst_n) begin
        check("model_valid", key_valid, exp_valid);
        check("model_code", key_code, exp_code);
        check("model_err", key_err, exp_err);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic apply(input logic [N_KEYS-1:0] p, input logic r);
    @(negedge clk);
    d = p;
    key_ready = r;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [N_KEYS-1:0] pat;
    int kind, len;

    #1 rst_n = 1'b0;
    #1;
    check("rst_valid", key_valid, 0);
    check("rst_code", key_code, 0);
    check("rst_err", key_err, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) tick();

    // single key 5 with ready held high: one valid cycle after edge 6
    apply(key(5), 1'b1);
    for (int e = 0; e < 8; e++) begin
      tick();
      check("t1_valid", key_valid, int'(e == 6));
      if (e == 6) check("t1_code", key_code, 5);
      check("t1_err", key_err, 0);
    end

    // key 9 with back-pressure for 5 cycles
    apply('0, 1'b1);
    repeat (10) tick();
    apply(key(9), 1'b0);
    for (int e = 0; e < 11; e++) begin
      tick();
      check("t2_valid", key_valid, int'(e >= 6));
      if (e >= 6) check("t2_code", key_code, 9);
    end
    apply(key(9), 1'b1);
    tick();
    check("t2_drop", key_valid, 0);
    for (int e = 0; e < 20; e++) begin
      tick();
      check("t2_no_repeat", key_valid, 0);
    end

    // bouncing key 3, then held
    apply('0, 1'b1);
    repeat (10) tick();
    for (int i = 0; i < 8; i++) begin
      apply(((i / 2) % 2 == 0) ? key(3) : '0, 1'b1);
      tick();
      check("t3_bounce", key_valid, 0);
    end
    apply(key(3), 1'b1);
    for (int e = 0; e < 8; e++) begin
      tick();
      check("t3_valid", key_valid, int'(e == 6));
      if (e == 6) check("t3_code", key_code, 3);
    end

    // multi-hot keys 1 and 4
    apply('0, 1'b1);
    repeat (10) tick();
    apply(10'b0000010010, 1'b1);
    for (int e = 0; e < 8; e++) begin
      tick();
      check("t4_err", key_err, int'(e == 6));
`ifdef KEY_PRIORITY_ENCODE_EN
      check("t4_valid", key_valid, int'(e == 6));
      if (e == 6) check("t4_code", key_code, 1);
`else
      check("t4_valid", key_valid, 0);
`endif
    end

    // release glitches of 2 and 3 cycles do not re-arm; 4 cycles do
    for (int g = 2; g <= 3; g++) begin
      apply('0, 1'b1);
      repeat (g) tick();
      apply(key(7), 1'b1);
      for (int e = 0; e < 15; e++) begin
        tick();
        check("t5_glitch", key_valid, 0);
      end
    end
    apply('0, 1'b1);
    repeat (4) tick();
    apply(key(7), 1'b1);
    for (int e = 0; e < 8; e++) begin
      tick();
      check("t5_valid", key_valid, int'(e == 6));
      if (e == 6) check("t5_code", key_code, 7);
    end

    // asynchronous reset during EMIT
    apply('0, 1'b0);
    repeat (10) tick();
    apply(key(2), 1'b0);
    for (int e = 0; e < 7; e++) begin
      tick();
      check("t6_pre_valid", key_valid, int'(e == 6));
      if (e == 6) check("t6_pre_code", key_code, 2);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_valid", key_valid, 0);
    check("t6_rst_code", key_code, 0);
    check("t6_rst_err", key_err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    key_ready = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      check("t6_post_valid", key_valid, int'(e == 6));
      if (e == 6) check("t6_post_code", key_code, 2);
    end

    // randomized segments, checked by the model every cycle
    apply('0, 1'b1);
    repeat (10) tick();
    for (int seg = 0; seg < 200; seg++) begin
      kind = int'($urandom_range(0, 3));
      len  = int'($urandom_range(1, 12));
      case (kind)
        0:       pat = '0;
        1:       pat = key(int'($urandom_range(0, N_KEYS - 1)));
        2:       pat = N_KEYS'($urandom);
        default: pat = key(int'($urandom_range(0, N_KEYS - 1)));
      endcase
      for (int c = 0; c < len; c++) begin
        apply((kind == 3 && (c % 2 == 1)) ? '0 : pat, ($urandom_range(0, 3) != 0));
        tick();
      end
    end

    apply('0, 1'b1);
    repeat (12) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
